// File: rtl/buffer_reader.sv
// buffer_reader: drains a 1-cycle-latency FIFO into a valid/ready stream
// through a two-entry skid store (head, tail).
// Optional feature: define BUFFER_READER_COUNT_EN to add the rd_count port,
// a wrapping count of words delivered to the consumer.
module buffer_reader #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] fifo_dout,
  input  logic         fifo_empty,
  output logic         fifo_rd_en,
  output logic [N-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
`ifdef BUFFER_READER_COUNT_EN
  ,
  output logic [N-1:0] rd_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e         state_q, state_d;
  logic         inflight_q, inflight_d;
  logic [N-1:0] head_q, head_d;
  logic [N-1:0] tail_q, tail_d;
  logic [2:0]   level;
  logic         capture;
  logic         pop;

  // A read issued last cycle always lands this cycle, so the in-flight flag
  // doubles as the capture strobe.
  assign capture = inflight_q;
  assign pop     = m_valid & m_ready;

  // State register: occupancy, in-flight flag and the two skid entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Next state: capture fills, pop drains; simultaneous capture and pop
  // shifts the store forward by one while holding occupancy.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = fifo_rd_en ? 1'b1 : (capture ? 1'b0 : inflight_q);
    case ({capture, pop})
      2'b10: begin
        case (state_q)
          EMPTY: begin
            head_d  = fifo_dout;
            state_d = ONE;
          end
          ONE: begin
            tail_d  = fifo_dout;
            state_d = TWO;
          end
          default: ;
        endcase
      end
      2'b01: begin
        case (state_q)
          ONE: state_d = EMPTY;
          TWO: begin
            head_d  = tail_q;
            state_d = ONE;
          end
          default: ;
        endcase
      end
      2'b11: begin
        case (state_q)
          ONE: head_d = fifo_dout;
          TWO: begin
            head_d = tail_q;
            tail_d = fifo_dout;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Outputs: stream from the head entry; read whenever the words already held
  // or in flight, less the one leaving now, leave room in the store.
  always_comb begin
    m_valid    = !rst && (state_q != EMPTY);
    m_data     = rst ? '0 : head_q;
    level      = {1'b0, state_q} + {2'b00, inflight_q};
    fifo_rd_en = !rst && !fifo_empty &&
                 (level < ((m_valid && m_ready) ? 3'd3 : 3'd2));
  end

`ifdef BUFFER_READER_COUNT_EN
  logic [N-1:0] count_q;

  // Delivered-word counter, wraps naturally at 2^N.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (pop) begin
      count_q <= count_q + N'(1);
    end
  end

  assign rd_count = count_q;
`endif

`ifndef SYNTHESIS
  // A full store must never receive a word unless one leaves the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(state_q == TWO && capture && !pop));
    end
  end
`endif

endmodule

// File: tb/tb_buffer_reader.sv
// Testbench for buffer_reader: a queue-based FIFO model feeds the DUT, a
// scoreboard queue holds the words expected on the stream, and a monitor
// compares every accepted word. Define BUFFER_READER_COUNT_EN to also
// exercise rd_count (N=4 in that build).
module tb_buffer_reader;

`ifdef BUFFER_READER_COUNT_EN
  localparam int unsigned N = 4;
`else
  localparam int unsigned N = 32;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] fifo_dout = '0;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [N-1:0] m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
`ifdef BUFFER_READER_COUNT_EN
  logic [N-1:0] rd_count;
`endif

  int checks = 0;
  int failures = 0;

  logic [N-1:0] fifo_q[$];
  logic [N-1:0] exp_q[$];
  int           pushed_cnt = 0;
  int           popped_cnt = 0;
  logic         gate_empty = 1'b0;

  assign fifo_empty = (pushed_cnt == popped_cnt) || gate_empty;

  always #5 clk = ~clk;

  buffer_reader #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
`ifdef BUFFER_READER_COUNT_EN
    ,
    .rd_count  (rd_count)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [N-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    pushed_cnt++;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(exp_q.size()), 0);
  endtask

  // FIFO model: read data appears one cycle after the strobe; reset flushes
  // the FIFO and everything the stream still owed.
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      exp_q.delete();
      popped_cnt <= pushed_cnt;
    end else if (fifo_rd_en && fifo_q.size() > 0) begin
      fifo_dout  <= fifo_q.pop_front();
      popped_cnt <= popped_cnt + 1;
    end
  end

  // Monitor: samples mid-cycle and checks outputs against the scoreboard.
  logic         prev_hold = 1'b0;
  logic [N-1:0] prev_data = '0;
`ifdef BUFFER_READER_COUNT_EN
  logic [N-1:0] cnt_model = '0;
`endif
  always @(negedge clk) begin
    if (rst) begin
      check("reset_outputs", 64'({fifo_rd_en, m_valid, m_data}), 0);
      prev_hold = 1'b0;
`ifdef BUFFER_READER_COUNT_EN
      cnt_model = '0;
`endif
    end else begin
      if (fifo_rd_en) check("no_underflow", 64'(fifo_empty), 0);
      if (prev_hold) check("hold_stable", 64'({m_valid, m_data}), 64'({1'b1, prev_data}));
`ifdef BUFFER_READER_COUNT_EN
      check("rd_count", 64'(rd_count), 64'(cnt_model));
`endif
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", m_data);
        end else begin
          check("stream_data", 64'(m_data), 64'(exp_q.pop_front()));
        end
`ifdef BUFFER_READER_COUNT_EN
        cnt_model = cnt_model + N'(1);
`endif
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_v, last_v, valid_cnt, rd_cnt, pop_cnt;
    logic [N-1:0] wb[4];
    logic [N-1:0] wa, wbb, wc;

    // Preloaded 5,7,9 with consumer ready, released from reset.
    tick();
    tick();
    tick();
    push(N'(5));
    push(N'(7));
    push(N'(9));
    m_ready = 1'b1;
    rst = 1'b0;
    first_v = -1;
    last_v = -1;
    valid_cnt = 0;
    rd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m_valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        valid_cnt++;
      end
      if (fifo_rd_en) rd_cnt++;
    end
    check("a_first_valid_cycle", 64'(first_v), 2);
    check("a_last_valid_cycle", 64'(last_v), 4);
    check("a_valid_cycles", 64'(valid_cnt), 3);
    check("a_rd_en_cycles", 64'(rd_cnt), 3);
    tick();
    check("a_drain", 64'(exp_q.size()), 0);

    // Stalled consumer with four words available.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb[i] = N'($urandom);
      push(wb[i]);
    end
    rd_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (fifo_rd_en) rd_cnt++;
    end
    check("b_rd_en_pulses", 64'(rd_cnt), 2);
    check("b_head_held", 64'({m_valid, m_data}), 64'({1'b1, wb[0]}));
    tick();
    m_ready = 1'b1;
    pop_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (m_valid && m_ready) pop_cnt++;
    end
    check("b_burst_pops", 64'(pop_cnt), 4);
    wait_drain("b_drain", 10);

    // Toggling empty flag and consumer over 100 random words.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 100; i++) push(N'($urandom));
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
      tick();
      gate_empty = ~gate_empty;
      if (i % 2 == 1) m_ready = ~m_ready;
    end
    check("c_drain", 64'(exp_q.size()), 0);
    gate_empty = 1'b0;

    // Reset on the capture cycle while one word is held.
    do_reset();
    m_ready = 1'b0;
    wa = N'($urandom);
    wbb = N'($urandom);
    wc = N'($urandom);
    push(wa);
    tick();
    tick();
    push(wbb);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("d_rst_cycle_out", 64'({m_valid, fifo_rd_en}), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("d_after_rst_out", 64'({m_valid, fifo_rd_en}), 0);
    tick();
    push(wc);
    m_ready = 1'b1;
    wait_drain("d_drain", 20);

    // Random traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      tick();
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) != 0 && fifo_q.size() < 8) push(N'($urandom));
      m_ready = $urandom_range(0, 1) != 0;
      gate_empty = ($urandom_range(0, 3) == 0);
    end
    tick();
    rst = 1'b0;
    gate_empty = 1'b0;
    m_ready = 1'b1;
    wait_drain("e_drain", 100);

`ifdef BUFFER_READER_COUNT_EN
    // Seventeen pops wrap a 4-bit count to 1; reset clears it.
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(N'($urandom));
    wait_drain("f_drain", 60);
    tick();
    check("f_rd_count_wrap", 64'(rd_count), 1);
    rst = 1'b1;
    tick();
    check("f_rd_count_reset", 64'(rd_count), 0);
    rst = 1'b0;
`endif

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/buffer_reader.md
BUFFER_READER -- requirements
Module: buffer_reader

Interface
REQ-001 SHALL have parameter N, default 32, data word width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port fifo_dout  input  N  FIFO read data, valid one cycle after fifo_rd_en.
REQ-005 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-006 SHALL have port fifo_rd_en  output  1  FIFO read strobe, one word per asserted cycle.
REQ-007 SHALL have port m_data  output  N  stream data to consumer.
REQ-008 SHALL have port m_valid  output  1  m_data holds a word.
REQ-009 SHALL have port m_ready  input  1  consumer accepts the word this cycle.
REQ-010 SHALL have port rd_count  output  N  delivered-word count, present only with BUFFER_READER_COUNT_EN.

Function
REQ-011 SHALL drain the sum FIFO on the read side and present its words as a valid/ready stream, in order, with no loss or duplication.
REQ-012 SHALL model FIFO read latency as exactly 1 cycle: a word read at cycle t is captured at the clk edge ending cycle t+1.
REQ-013 SHALL hold captured words in a 2-entry skid store (head, tail); the occupancy FSM has states EMPTY (0), ONE (1) and TWO (2).
REQ-014 SHALL track in-flight reads in a 1-bit flag set on a fifo_rd_en cycle and cleared on the capture cycle.
REQ-015 SHALL assert fifo_rd_en combinationally when fifo_empty=0 and (occupancy + inflight - pop) < 2, where pop = m_valid & m_ready; this gives one word per cycle sustained.
REQ-016 SHALL drive m_valid = 1 in states ONE and TWO; m_data = head entry; m_data is don't-care when m_valid=0.
REQ-017 SHALL keep m_data and m_valid stable while m_valid=1 and m_ready=0.
REQ-018 FSM transitions: capture-only increments occupancy; pop-only decrements; capture and pop in the same cycle holds occupancy, and tail or capture moves to head.
REQ-019 SHALL never capture in state TWO without a simultaneous pop; REQ-015 guarantees this, and the assertion in REQ-029 checks it.
REQ-020 SHALL ignore fifo_dout on cycles with no capture.
REQ-021 SHALL never assert fifo_rd_en while fifo_empty=1, so no underflow reads occur.
REQ-022 m_ready=1 with m_valid=0 SHALL have no effect.
REQ-023 Latency: a word in a non-empty FIFO with an idle reader SHALL appear on m_valid 2 cycles after fifo_empty falls (read cycle, capture edge).

Reset
REQ-024 SHALL, while rst=1 at a clk edge: occupancy -> EMPTY, inflight -> 0, head and tail -> 0, rd_count -> 0.
REQ-025 SHALL hold outputs during reset: fifo_rd_en = 0, m_valid = 0, m_data = 0.
REQ-026 SHALL discard any in-flight word on rst mid-operation; the FIFO shares rst and is flushed in the same cycle.
REQ-027 SHALL resume normal operation on the first edge after rst deasserts.

Configuration
REQ-028 Macro BUFFER_READER_COUNT_EN defined: rd_count port exists; it increments by 1 on each pop, wraps from 2^N-1 to 0, and resets to 0.
REQ-029 Macro undefined: rd_count port and counter logic are absent; all other behaviour is identical. A simulation-only assertion flags capture in TWO without pop in both builds.

Verification
REQ-030 Scenario: FIFO preloaded with 5, 7, 9; m_ready=1; rst released -> m_data 5, 7, 9 on three consecutive cycles, first word 2 cycles after release; fifo_rd_en asserted exactly 3 cycles total.
REQ-031 Scenario: m_ready=0 with 4 words available -> fifo_rd_en pulses exactly twice; FSM reaches TWO; m_data holds the first word; raising m_ready delivers all 4 words in order at 1 word/cycle.
REQ-032 Scenario: fifo_empty toggles every cycle and m_ready toggles every other cycle over 100 random words -> output sequence equals input sequence; no fifo_rd_en while fifo_empty=1.
REQ-033 Scenario: rst asserted on the capture cycle of a read with occupancy 1 -> next cycle m_valid=0, fifo_rd_en=0; after release the first new FIFO word is delivered correctly.
REQ-034 Scenario (BUFFER_READER_COUNT_EN, N=4): 17 pops -> rd_count = 1 (wrapped after 15); rst -> 0.
REQ-035 Scenario (macro undefined): the bench compiles without the rd_count connection, and REQ-030 passes unchanged.
